// File: rtl/mem_slave_responder.sv
// Word-addressed RAM slave terminating one crossbar slave port.
// Inserts LATENCY wait states after sampling a request, then returns a one-cycle ack.
module mem_slave_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        cmd,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  if (LATENCY < 0 || LATENCY > 15) begin : g_latency_check
    $error("mem_slave_responder: LATENCY must be in 0..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              enter_ack;
  logic [ADDR_W-1:0] idx_q;
  logic              cmd_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_cmd;
  logic [31:0]       acc_wdata;
  logic [31:0]       mem [DEPTH];

  // Only the word-index bits select a location; everything else aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

  // With LATENCY=0 the access happens on the sampling edge, so use the live request.
  assign acc_idx   = (state == IDLE) ? addr[ADDR_W+1:2] : idx_q;
  assign acc_cmd   = (state == IDLE) ? cmd              : cmd_q;
  assign acc_wdata = (state == IDLE) ? wdata            : wdata_q;

  assign busy = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    enter_ack = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            state_nx  = ACK;
            enter_ack = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nx = IDLE;
        end else if (cnt == 4'd0) begin
          state_nx  = ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ack   <= 1'b0;
      rdata <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ack   <= enter_ack;
      if (enter_ack && !acc_cmd) begin
        rdata <= mem[acc_idx];
      end
    end
  end

  // Request fields are captured only on the sampling edge; changes during WAIT are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      idx_q   <= addr[ADDR_W+1:2];
      cmd_q   <= cmd;
      wdata_q <= wdata;
    end
  end

  // NOTE: the memory array is deliberately not reset; it maps onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (!rst && enter_ack && acc_cmd) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule
